instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Sequences the combinational word-addressed instruction memory (read data returned in the same cycle as the address; word index = address[31:2]).
- Owns the fetch PC, drives the memory address and captures each returned word together with its PC.
- Buffers fetched words in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirects (branch/jump), flushes and fetch faults (out-of-range or misaligned target).

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, PC loaded at reset; word-aligned
MEM_WORDS, 7, number of valid words in instruction memory; legal fetch requires PC[31:2] < MEM_WORDS

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  one-cycle pulse; begins fetching at current PC when IDLE
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  redirect target byte address
imem_addr  output  32  address to instruction memory; equals PC register
imem_rdata  input  32  instruction memory read data (combinational from imem_addr)
instr_valid  output  1  FIFO head valid (count != 0)
instr_ready  input  1  decode accepts head this cycle
instr_out  output  32  instruction at FIFO head
instr_pc  output  32  PC of the instruction at FIFO head
fault  output  1  fetch halted on a fault
fault_pc  output  32  address that caused the fault
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0, async): state IDLE, PC=RESET_PC, count=0, all FIFO storage 0, fault=0, fault_pc=0. Hence imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fifo_count=0.
- States: IDLE, FETCH, FAULT.
- IDLE: no pushes. start -> FETCH with PC unchanged.
- FETCH: each cycle evaluate push = (count<DEPTH) || pop, where pop = instr_valid && instr_ready.
  - Push and PC[31:2] < MEM_WORDS: write {PC, imem_rdata} at tail, PC <= PC+4.
  - Push and PC[31:2] >= MEM_WORDS: no write, state <= FAULT, fault <= 1, fault_pc <= PC, PC holds.
  - No push (FIFO full, no pop): PC holds, no range check.
- FAULT: no pushes; buffered entries still drain normally. start is ignored; only a redirect leaves FAULT.
- Pop: head advances at the edge where pop=1. Simultaneous push and pop leaves count unchanged. instr_out/instr_pc must stay stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, any state, including IDLE): at the edge, count <= 0 and any same-cycle push is discarded. A same-cycle pop counts as consumed by decode. fault <= 0.
  - redirect_pc[1:0] == 0: PC <= redirect_pc, state <= FETCH. The range check occurs on the next fetch.
  - redirect_pc[1:0] != 0: state <= FAULT, fault <= 1, fault_pc <= redirect_pc, PC <= redirect_pc.
- start together with redirect_valid: redirect wins; start is ignored.
- Latency:
  - start sampled at edge k -> first push at edge k+1 -> instr_valid=1 after k+1.
  - Redirect at edge k -> instr_valid=0 after k -> first new-target instruction valid after k+1.
- Arithmetic: PC+4 is modulo 2^32. The range check keeps PC from reaching wrap in practice.
- FIFO pointers: $clog2(DEPTH) bits, wrap naturally. count saturates only by construction and is never written above DEPTH.

Test Plan:
- Reset then start, instr_ready=1, memory words 0..6 = 32'h00000013+i -> instr_out sequence 0x13..0x19 with instr_pc 0x00..0x18, one per cycle; at PC 0x1C fault=1, fault_pc=0x1C, instr_valid drops after the last word.
- start with instr_ready=0 -> fifo_count rises 1..4 then holds, imem_addr holds at 0x10; raise instr_ready -> head 0x13 accepted, a push happens in the same cycle, count stays 4.
- With 3 entries buffered, redirect_valid with redirect_pc=0x08 -> next cycle count=0, instr_valid=0; following cycle instr_pc=0x08, instr_out=word 2.
- In FAULT (fault_pc=0x1C), redirect_pc=0x04 -> fault=0, fetch resumes, instr_pc=0x04 next. Also: in FAULT, pulse start -> no change.
- redirect_pc=0x06 -> fault=1, fault_pc=0x06, no pushes until a redirect to 0x00 restarts fetch.
- Assert rst_n=0 asynchronously mid-FETCH with a full FIFO -> outputs go to reset values immediately without a clock edge; after release, IDLE with imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port plus decode handshake.
// Master is the fetch controller, slave is the memory/decode side.
interface instr_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads a combinational
// instruction memory and buffers words in a prefetch FIFO for decode.
module instr_fetch_ctrl #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    instr_fetch_ctrl_if.master         bus,
    output logic                       fault,
    output logic [31:0]                fault_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [29:0] MEM_LIM = 30'(MEM_WORDS);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            fault_q, fault_d;
    logic [31:0]     fault_pc_q, fault_pc_d;
    logic [31:0]     ins_q [DEPTH];
    logic [31:0]     ins_d [DEPTH];
    logic [31:0]     ipc_q [DEPTH];
    logic [31:0]     ipc_d [DEPTH];

    logic pop;
    logic push;
    logic in_range;

    assign pop      = (count_q != '0) && bus.instr_ready;
    assign push     = (state_q == FETCH) && ((count_q != FULL) || pop);
    assign in_range = pc_q[31:2] < MEM_LIM;

    // Next state, PC, FIFO bookkeeping and fault tracking.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        ins_d      = ins_q;
        ipc_d      = ipc_q;

        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fault_d  = 1'b0;
            pc_d     = redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state_d = FETCH;
            end else begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (push && in_range) begin
                        ins_d[wr_ptr_q] = bus.imem_rdata;
                        ipc_d[wr_ptr_q] = pc_q;
                        wr_ptr_d        = wr_ptr_q + 1'b1;
                        pc_d            = pc_q + 32'd4;
                    end else if (push) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end
                end
                default: begin
                end
            endcase

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q
                    + CW'(push && in_range)
                    - CW'(pop);
        end
    end

    // State and FIFO registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= '0;
                ipc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            ins_q      <= ins_d;
            ipc_q      <= ipc_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_out   = ins_q[rd_ptr_q];
    assign bus.instr_pc    = ipc_q[rd_ptr_q];
    assign fault           = fault_q;
    assign fault_pc        = fault_pc_q;
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam int MEM_WORDS = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fault;
    logic [31:0] fault_pc;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(
        .DEPTH(DEPTH),
        .RESET_PC(32'h0),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .fault(fault),
        .fault_pc(fault_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Memory: words 0..6 hold 0x13+i, anything beyond is garbage.
    assign bus.imem_rdata = (bus.imem_addr[31:2] < 30'(MEM_WORDS))
        ? 32'h13 + {2'b00, bus.imem_addr[31:2]}
        : 32'hDEAD_BEEF;

    initial bus.instr_ready = 1'b0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    // Reference model: mode 0 idle, 1 fetching, 2 faulted.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    int          m_mode;
    logic        m_fault;
    logic [31:0] m_fpc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc = 32'h0;
            m_mode = 0;
            m_fault = 1'b0;
            m_fpc = 32'h0;
        end else begin
            bit p_pop;
            bit p_push;
            p_pop  = (mq.size() != 0) && bus.instr_ready;
            p_push = (m_mode == 1) && ((mq.size() < DEPTH) || p_pop);
            if (redirect_valid) begin
                mq.delete();
                m_fault = 1'b0;
                m_pc = redirect_pc;
                if (redirect_pc % 4 == 0) begin
                    m_mode = 1;
                end else begin
                    m_mode = 2;
                    m_fault = 1'b1;
                    m_fpc = redirect_pc;
                end
            end else begin
                if (p_pop) void'(mq.pop_front());
                if (m_mode == 0 && start) begin
                    m_mode = 1;
                end else if (p_push) begin
                    if (m_pc / 4 < MEM_WORDS) begin
                        mq.push_back({m_pc, 32'h13 + m_pc / 4});
                        m_pc = m_pc + 4;
                    end else begin
                        m_mode = 2;
                        m_fault = 1'b1;
                        m_fpc = m_pc;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", {31'b0, bus.instr_valid},
                {31'b0, mq.size() != 0});
            chk("m_count", {29'b0, fifo_count}, mq.size());
            chk("m_addr", bus.imem_addr, m_pc);
            chk("m_fault", {31'b0, fault}, {31'b0, m_fault});
            chk("m_fault_pc", fault_pc, m_fpc);
            if (mq.size() != 0) begin
                chk("m_instr_out", bus.instr_out, mq[0][31:0]);
                chk("m_instr_pc", bus.instr_pc, mq[0][63:32]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_out", bus.instr_out, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_count", {29'b0, fifo_count}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        tick(2);
        chk("idle_no_push", {31'b0, bus.instr_valid}, 32'h0);

        // Streaming run to the end of memory.
        bus.instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_lat", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("stream_out", bus.instr_out, 32'h13 + i);
            chk("stream_pc", bus.instr_pc, 32'(4 * i));
            tick();
        end
        chk("end_fault", {31'b0, fault}, 32'h1);
        chk("end_fault_pc", fault_pc, 32'h1C);
        chk("end_valid", {31'b0, bus.instr_valid}, 32'h0);

        // start is ignored while faulted.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("flt_start_fault", {31'b0, fault}, 32'h1);
        chk("flt_start_addr", bus.imem_addr, 32'h1C);
        chk("flt_start_valid", {31'b0, bus.instr_valid}, 32'h0);

        // Redirect out of fault.
        redirect_valid = 1'b1;
        redirect_pc = 32'h04;
        tick();
        redirect_valid = 1'b0;
        chk("rd4_fault", {31'b0, fault}, 32'h0);
        chk("rd4_valid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        chk("rd4_pc", bus.instr_pc, 32'h04);
        chk("rd4_out", bus.instr_out, 32'h14);
        tick(10);

        // Fill with decode stalled.
        do_reset();
        bus.instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("fill_count", {29'b0, fifo_count}, 32'(i));
        end
        tick(2);
        chk("full_count", {29'b0, fifo_count}, 32'h4);
        chk("full_addr", bus.imem_addr, 32'h10);
        chk("stall_out", bus.instr_out, 32'h13);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("pp_count", {29'b0, fifo_count}, 32'h4);
        chk("pp_out", bus.instr_out, 32'h14);
        chk("pp_addr", bus.imem_addr, 32'h14);

        // Redirect with three entries buffered.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
        chk("three_count", {29'b0, fifo_count}, 32'h3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h08;
        tick();
        redirect_valid = 1'b0;
        chk("rd8_count", {29'b0, fifo_count}, 32'h0);
        chk("rd8_valid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        chk("rd8_pc", bus.instr_pc, 32'h08);
        chk("rd8_out", bus.instr_out, 32'h15);

        // Misaligned redirect, then recover.
        redirect_valid = 1'b1;
        redirect_pc = 32'h06;
        tick();
        redirect_valid = 1'b0;
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h06);
        tick(2);
        chk("mis_count", {29'b0, fifo_count}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h00;
        tick();
        redirect_valid = 1'b0;
        chk("rec_fault", {31'b0, fault}, 32'h0);
        tick();
        chk("rec_pc", bus.instr_pc, 32'h00);
        chk("rec_count", {29'b0, fifo_count}, 32'h1);

        // start and redirect together from IDLE.
        do_reset();
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0C;
        tick();
        start = 1'b0;
        redirect_valid = 1'b0;
        chk("sr_addr", bus.imem_addr, 32'h0C);
        tick();
        chk("sr_out", bus.instr_out, 32'h16);

        // Async reset with a full FIFO.
        tick(4);
        chk("pre_rst_count", {29'b0, fifo_count}, 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("async_count", {29'b0, fifo_count}, 32'h0);
        chk("async_addr", bus.imem_addr, 32'h0);
        chk("async_out", bus.instr_out, 32'h0);
        chk("async_pc", bus.instr_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(2);
        chk("post_addr", bus.imem_addr, 32'h0);
        chk("post_valid", {31'b0, bus.instr_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
